// File: rtl/fnd_pkg.sv
// Shared types and segment codes for the FND result display.
// Segment byte layout is {dp,g,f,e,d,c,b,a}, active low (common anode).
package fnd_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [7:0] seg_t;

  localparam int unsigned NUM_DIGITS = 4;

  localparam seg_t SEG_0     = 8'hC0;
  localparam seg_t SEG_1     = 8'hF9;
  localparam seg_t SEG_2     = 8'hA4;
  localparam seg_t SEG_3     = 8'hB0;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h92;
  localparam seg_t SEG_6     = 8'h82;
  localparam seg_t SEG_7     = 8'hF8;
  localparam seg_t SEG_8     = 8'h80;
  localparam seg_t SEG_9     = 8'h90;
  localparam seg_t SEG_A     = 8'h88;
  localparam seg_t SEG_S     = 8'h92;
  localparam seg_t SEG_MINUS = 8'hBF;
  localparam seg_t SEG_BLANK = 8'hFF;

  // Symbol codes fed to the segment decoder beyond the decimal digits.
  localparam logic [3:0] CODE_A     = 4'd10;
  localparam logic [3:0] CODE_S     = 4'd11;
  localparam logic [3:0] CODE_MINUS = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational symbol-code to seven-segment decoder; blank flag overrides the code.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_blank,
  output seg_t       o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    if (!i_blank) begin
      case (i_code)
        4'd0:       o_seg_c = SEG_0;
        4'd1:       o_seg_c = SEG_1;
        4'd2:       o_seg_c = SEG_2;
        4'd3:       o_seg_c = SEG_3;
        4'd4:       o_seg_c = SEG_4;
        4'd5:       o_seg_c = SEG_5;
        4'd6:       o_seg_c = SEG_6;
        4'd7:       o_seg_c = SEG_7;
        4'd8:       o_seg_c = SEG_8;
        4'd9:       o_seg_c = SEG_9;
        CODE_A:     o_seg_c = SEG_A;
        CODE_S:     o_seg_c = SEG_S;
        CODE_MINUS: o_seg_c = SEG_MINUS;
        default:    o_seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fnd_result_display.sv
// Latches the adder/subtractor result and scans it as signed decimal on a 4-digit FND.
// Optional overflow blink is enabled by defining FND_OVF_BLINK_EN.
module fnd_result_display
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
`ifdef FND_OVF_BLINK_EN
  , parameter int unsigned BLINK_DIV = 256
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [3:0] i_Sum,
  input  logic       i_Cout,
  input  logic       i_Mode,
  output logic [7:0] o_seg,
  output logic [3:0] o_an,
  output logic       o_busy
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);

  logic [PRE_W-1:0] r_pre;
  digit_idx_t       r_idx;
  logic [3:0]       r_sum;
  logic             r_cout;
  logic             r_mode;
  seg_t             r_seg;
  logic [3:0]       r_an;
  logic             r_busy;

  logic       w_tick;
  logic [4:0] w_mag;
  logic       w_neg;
  logic [1:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_code;
  logic       w_blank;
  logic       w_blink_off;
  seg_t       w_seg;

  assign w_tick = (r_pre == PRE_W'(CLK_DIV - 1));

  // Signed magnitude of the latched result.
  always_comb begin
    w_mag = 5'd0;
    w_neg = 1'b0;
    if (!r_mode) begin
      w_mag = {r_cout, r_sum};
    end else if (r_cout) begin
      w_mag = {1'b0, r_sum};
    end else begin
      w_mag = {1'b0, 4'(~r_sum + 4'd1)};
      w_neg = 1'b1;
    end
  end

  // Magnitude tops out at 30, so a three-step compare/subtract covers tens.
  always_comb begin
    w_tens = 2'd0;
    w_ones = w_mag[3:0];
    if (w_mag >= 5'd30) begin
      w_tens = 2'd3;
      w_ones = 4'(w_mag - 5'd30);
    end else if (w_mag >= 5'd20) begin
      w_tens = 2'd2;
      w_ones = 4'(w_mag - 5'd20);
    end else if (w_mag >= 5'd10) begin
      w_tens = 2'd1;
      w_ones = 4'(w_mag - 5'd10);
    end
  end

  always_comb begin
    w_code  = CODE_BLANK;
    w_blank = w_blink_off;
    case (r_idx)
      2'd3:    w_code = r_mode ? CODE_S : CODE_A;
      2'd2:    w_code = w_neg ? CODE_MINUS : CODE_BLANK;
      2'd1: begin
        w_code  = {2'b00, w_tens};
        w_blank = w_blink_off | (w_tens == 2'd0);
      end
      default: w_code = w_ones;
    endcase
  end

  fnd_seg_decoder u_dec (
    .i_code  (w_code),
    .i_blank (w_blank),
    .o_seg_c (w_seg)
  );

`ifdef FND_OVF_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_off;
  logic             w_ovf;

  assign w_ovf       = ~r_mode & r_cout;
  assign w_blink_off = r_blink_off;

  // Phase restarts "on" at each capture and only advances while overflowed.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_valid || !w_ovf) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end
`else
  assign w_blink_off = 1'b0;
`endif

  // Capture, prescaler, digit index and registered display outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre  <= '0;
      r_idx  <= 2'd0;
      r_sum  <= 4'd0;
      r_cout <= 1'b0;
      r_mode <= 1'b0;
      r_seg  <= SEG_BLANK;
      r_an   <= 4'b1111;
      r_busy <= 1'b0;
    end else begin
      r_busy <= 1'b0;
      if (i_valid) begin
        r_sum  <= i_Sum;
        r_cout <= i_Cout;
        r_mode <= i_Mode;
      end
      if (w_tick) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
        r_an  <= an_select(r_idx);
        r_seg <= w_seg;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  assign o_seg  = r_seg;
  assign o_an   = r_an;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_fnd_result_display.sv
// Self-checking bench: directed display scans plus randomized captures against a cycle-count model.
module tb_fnd_result_display;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [3:0] i_Sum = 4'd0;
  logic       i_Cout = 1'b0;
  logic       i_Mode = 1'b0;
  logic [7:0] o_seg;
  logic [3:0] o_an;
  logic       o_busy;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] dig [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] seen [4];

  // Model state: edges since reset, latched operands, expected outputs.
  int         m_n = 0;
  logic [3:0] m_s = 4'd0;
  logic       m_c = 1'b0;
  logic       m_m = 1'b0;
  logic [7:0] m_seg = 8'hFF;
  logic [3:0] m_an = 4'hF;

  always #5 clk = ~clk;

  fnd_result_display #(
    .CLK_DIV(CLK_DIV)
`ifdef FND_OVF_BLINK_EN
    , .BLINK_DIV(2)
`endif
  ) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_Sum   (i_Sum),
    .i_Cout  (i_Cout),
    .i_Mode  (i_Mode),
    .o_seg   (o_seg),
    .o_an    (o_an),
    .o_busy  (o_busy)
  );

  function automatic logic [7:0] exp_seg(input int idx, input logic [3:0] s,
                                         input logic c, input logic m);
    int  mag;
    bit  neg;
    neg = m && !c;
    if (!m)     mag = 16 * int'(c) + int'(s);
    else if (c) mag = int'(s);
    else        mag = (16 - int'(s)) % 16;
    case (idx)
      3:       return m ? 8'h92 : 8'h88;
      2:       return neg ? 8'hBF : 8'hFF;
      1:       return (mag / 10 == 0) ? 8'hFF : dig[mag / 10];
      default: return dig[mag % 10];
    endcase
  endfunction

  // Each slot boundary (every CLK_DIV edges after reset) shows the next digit, in order 0,1,2,3.
  always @(posedge clk) begin
    if (i_reset) begin
      m_n = 0; m_s = 4'd0; m_c = 1'b0; m_m = 1'b0;
      m_seg = 8'hFF; m_an = 4'hF;
    end else begin
      m_n = m_n + 1;
      if (m_n % CLK_DIV == 0) begin
        int k;
        logic [3:0] one;
        one = 4'b0001;
        k = (m_n / CLK_DIV - 1) % 4;
        m_an = ~(one << k);
        m_seg = exp_seg(k, m_s, m_c, m_m);
      end
      if (i_valid) begin
        m_s = i_Sum; m_c = i_Cout; m_m = i_Mode;
      end
    end
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    logic [3:0] one;
    one = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    chk("scan", {o_an, o_seg}, {m_an, m_seg});
    chk("busy", 12'(o_busy), 12'd0);
    for (int i = 0; i < 4; i++)
      if (o_an == ~(one << i)) seen[i] = o_seg;
  endtask

  task automatic capture(input logic [3:0] s, input logic c, input logic m);
    i_Sum = s; i_Cout = c; i_Mode = m; i_valid = 1'b1;
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic scan_expect(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
    repeat (CLK_DIV) cyc();
    for (int i = 0; i < 4; i++) seen[i] = 8'h00;
    repeat (4 * CLK_DIV) cyc();
    chk({tag, "_d3"}, 12'(seen[3]), 12'(e3));
    chk({tag, "_d2"}, 12'(seen[2]), 12'(e2));
    chk({tag, "_d1"}, 12'(seen[1]), 12'(e1));
    chk({tag, "_d0"}, 12'(seen[0]), 12'(e0));
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_an", 12'(o_an), 12'hF);
    chk("rst_seg", 12'(o_seg), 12'hFF);
    i_reset = 1'b0;

    capture(4'd2, 1'b1, 1'b0);
    scan_expect("add18", 8'h88, 8'hFF, 8'hF9, 8'h80);
    capture(4'd1, 1'b1, 1'b1);
    scan_expect("sub1", 8'h92, 8'hFF, 8'hFF, 8'hF9);
    capture(4'b1110, 1'b0, 1'b1);
    scan_expect("neg2", 8'h92, 8'hBF, 8'hFF, 8'hA4);

    // Inputs move without a strobe; display must not follow.
    i_Sum = 4'd7; i_Cout = 1'b1; i_Mode = 1'b0;
    repeat (CLK_DIV) cyc();
    scan_expect("hold", 8'h92, 8'hBF, 8'hFF, 8'hA4);

    // Strobe on a tick edge: that load shows the old value, the next one the new.
    for (int g = 0; g < 2 * CLK_DIV && ((m_n + 1) % CLK_DIV) != 0; g++) cyc();
    capture(4'd5, 1'b1, 1'b0);
    k = (m_n / CLK_DIV - 1) % 4;
    chk("coinc_old", 12'(o_seg), 12'(exp_seg(k, 4'b1110, 1'b0, 1'b1)));
    repeat (CLK_DIV) cyc();
    chk("coinc_new", 12'(o_seg), 12'(exp_seg((k + 1) % 4, 4'd5, 1'b1, 1'b0)));
    scan_expect("add21", 8'h88, 8'hFF, 8'hA4, 8'hF9);

    // Reset mid-slot, then first digit appears one slot later as '0'.
    repeat (CLK_DIV / 2 + 1) cyc();
    i_reset = 1'b1;
    cyc();
    chk("mrst_an", 12'(o_an), 12'hF);
    chk("mrst_seg", 12'(o_seg), 12'hFF);
    i_reset = 1'b0;
    repeat (CLK_DIV - 1) cyc();
    chk("mrst_blank", {o_an, o_seg}, 12'hFFF);
    cyc();
    chk("mrst_an0", {o_an, o_seg}, {4'b1110, 8'hC0});

    // Random captures, input noise between strobes and occasional resets.
    for (int it = 0; it < 150; it++) begin
      int gap;
      gap = int'($urandom_range(0, 3 * CLK_DIV));
      for (int g = 0; g < gap; g++) begin
        i_Sum = 4'($urandom); i_Cout = 1'($urandom); i_Mode = 1'($urandom);
        cyc();
      end
      if ($urandom_range(0, 39) == 0) begin
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
      end
      capture(4'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (4 * CLK_DIV) cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
